// File: rtl/mult_div_unit.sv
// Iterative 32-bit multiply/divide unit with architectural HI/LO registers.
// Operations take a fixed 33 cycles: 32 shift iterations, then a sign-fixup/writeback cycle.
module mult_div_unit (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic        hi_we,
   input  logic        lo_we,
   input  logic [31:0] wdata,
   output logic        busy,
   output logic        done,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   typedef enum logic [1:0] {IDLE, RUN, SIGN} state_t;

   state_t      state_q;
   logic [4:0]  count_q;
   logic        is_div_q, neg_q, rneg_q, dz_q;
   logic [31:0] a_raw_q, mcand_q;
   logic [31:0] acc_hi_q, acc_lo_q;
   logic [31:0] hi_q, lo_q;
   logic        busy_q, done_q;

   logic        a_neg, b_neg;
   logic [31:0] a_mag, b_mag;
   logic [32:0] mul_sum, div_shift, div_diff;
   logic [63:0] prod, prod_fix;
   logic [31:0] quo_fix, rem_fix;

   // op[0] selects signed; magnitudes feed an unsigned core
   assign a_neg = op[0] & A[31];
   assign b_neg = op[0] & B[31];
   assign a_mag = a_neg ? (~A + 32'd1) : A;
   assign b_mag = b_neg ? (~B + 32'd1) : B;

   assign mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, mcand_q} : 33'd0);
   assign div_shift = {acc_hi_q, acc_lo_q[31]};
   assign div_diff  = div_shift - {1'b0, mcand_q};

   assign prod     = {acc_hi_q, acc_lo_q};
   assign prod_fix = neg_q  ? (~prod + 64'd1) : prod;
   assign quo_fix  = neg_q  ? (~acc_lo_q + 32'd1) : acc_lo_q;
   assign rem_fix  = rneg_q ? (~acc_hi_q + 32'd1) : acc_hi_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         count_q  <= 5'd0;
         is_div_q <= 1'b0;
         neg_q    <= 1'b0;
         rneg_q   <= 1'b0;
         dz_q     <= 1'b0;
         a_raw_q  <= 32'd0;
         mcand_q  <= 32'd0;
         acc_hi_q <= 32'd0;
         acc_lo_q <= 32'd0;
         hi_q     <= 32'd0;
         lo_q     <= 32'd0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (hi_we) hi_q <= wdata;
               if (lo_we) lo_q <= wdata;
               if (start) begin
                  // multiply: acc_lo holds multiplier; divide: acc_lo holds dividend
                  is_div_q <= op[1];
                  neg_q    <= a_neg ^ b_neg;
                  rneg_q   <= a_neg;
                  dz_q     <= op[1] & (B == 32'd0);
                  a_raw_q  <= A;
                  mcand_q  <= op[1] ? b_mag : a_mag;
                  acc_hi_q <= 32'd0;
                  acc_lo_q <= op[1] ? a_mag : b_mag;
                  count_q  <= 5'd0;
                  busy_q   <= 1'b1;
                  state_q  <= RUN;
               end
            end
            RUN: begin
               if (is_div_q) begin
                  if (!div_diff[32]) begin
                     acc_hi_q <= div_diff[31:0];
                     acc_lo_q <= {acc_lo_q[30:0], 1'b1};
                  end else begin
                     acc_hi_q <= div_shift[31:0];
                     acc_lo_q <= {acc_lo_q[30:0], 1'b0};
                  end
               end else begin
                  {acc_hi_q, acc_lo_q} <= {mul_sum, acc_lo_q[31:1]};
               end
               count_q <= count_q + 5'd1;
               if (count_q == 5'd31) state_q <= SIGN;
            end
            SIGN: begin
               if (dz_q) begin
                  // divide by zero reports the raw dividend, not a sign-fixed one
                  hi_q <= a_raw_q;
                  lo_q <= 32'hFFFF_FFFF;
               end else if (is_div_q) begin
                  hi_q <= rem_fix;
                  lo_q <= quo_fix;
               end else begin
                  hi_q <= prod_fix[63:32];
                  lo_q <= prod_fix[31:0];
               end
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign HI   = hi_q;
   assign LO   = lo_q;

endmodule
